// File: rtl/arm_ldm_sequencer.sv
// rtl/arm_ldm_sequencer.sv - LDM/STM micro-op sequencer; optional LDM_BASE_IN_LIST_EN drops writeback when a load reloads its base
module arm_ldm_sequencer #(
    parameter int NREGS = 16,
    parameter int OFFW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NREGS-1:0] regList,
    input  logic [3:0]       Rn,
    input  logic             isLoad,
    input  logic             wb,
    input  logic             isAdd,
    input  logic             pre,
    input  logic             stallD,
    input  logic             FlushE,
    output logic             busy,
    output logic             StallF,
    output logic             uopValid,
    output logic [3:0]       uopReg,
    output logic [OFFW-1:0]  uopOffset,
    output logic             uopLoad,
    output logic             uopPC,
    output logic             wbValid,
    output logic [OFFW-1:0]  wbOffset,
    output logic             done
);

    localparam int CW = $clog2(NREGS + 1);

`ifdef LDM_BASE_IN_LIST_EN
    localparam logic BASE_IN_LIST_EN = 1'b1;
`else
    localparam logic BASE_IN_LIST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB} state_t;

    state_t           state;
    logic [NREGS-1:0] remain;
    logic [CW-1:0]    n_regs;
    logic             wb_q;
    logic             add_q;

    logic [CW-1:0]    acc_n;
    logic [OFFW-1:0]  acc_n4;
    logic [OFFW-1:0]  q_n4;
    logic [OFFW-1:0]  start_off;
    logic             acc_wb;
    logic [3:0]       first_reg;
    logic [NREGS-1:0] first_rest;
    logic             first_last;
    logic [3:0]       next_reg;
    logic [NREGS-1:0] next_rest;
    logic             next_last;

    function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [NREGS-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = NREGS - 1; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    always_comb begin
        acc_n  = popcount(regList);
        acc_n4 = OFFW'(acc_n) << 2;
        q_n4   = OFFW'(n_regs) << 2;
        // Lowest address of the block; registers always ascend from here.
        case ({pre, isAdd})
            2'b01:   start_off = '0;
            2'b11:   start_off = OFFW'(4);
            2'b00:   start_off = OFFW'(4) - acc_n4;
            default: start_off = '0 - acc_n4;
        endcase
        acc_wb     = wb & ~(BASE_IN_LIST_EN & isLoad & regList[Rn]);
        first_reg  = lowest_set(regList);
        first_rest = regList & (regList - NREGS'(1));
        first_last = (first_rest == '0) & ~acc_wb;
        next_reg   = lowest_set(remain);
        next_rest  = remain & (remain - NREGS'(1));
        next_last  = (next_rest == '0) & ~wb_q;
    end

    always_ff @(posedge clk) begin
        // Any advancing cycle starts from an idle, all-zero output set.
        if (rst || FlushE || !stallD) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            StallF    <= 1'b0;
            uopValid  <= 1'b0;
            uopReg    <= '0;
            uopOffset <= '0;
            uopLoad   <= 1'b0;
            uopPC     <= 1'b0;
            wbValid   <= 1'b0;
            wbOffset  <= '0;
            done      <= 1'b0;
        end
        if (rst || FlushE) begin
            remain <= '0;
            n_regs <= '0;
            wb_q   <= 1'b0;
            add_q  <= 1'b0;
        end else if (!stallD) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wb_q   <= acc_wb;
                        add_q  <= isAdd;
                        n_regs <= acc_n;
                        remain <= first_rest;
                        if (acc_n != '0) begin
                            state     <= S_XFER;
                            busy      <= 1'b1;
                            StallF    <= ~first_last;
                            uopValid  <= 1'b1;
                            uopReg    <= first_reg;
                            uopOffset <= start_off;
                            uopLoad   <= isLoad;
                            uopPC     <= isLoad & (first_reg == 4'd15);
                            done      <= first_last;
                        end else if (acc_wb) begin
                            state   <= S_WB;
                            busy    <= 1'b1;
                            wbValid <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
                    if (remain != '0) begin
                        state     <= S_XFER;
                        busy      <= 1'b1;
                        StallF    <= ~next_last;
                        uopValid  <= 1'b1;
                        uopReg    <= next_reg;
                        uopOffset <= uopOffset + OFFW'(4);
                        uopLoad   <= uopLoad;
                        uopPC     <= uopLoad & (next_reg == 4'd15);
                        remain    <= next_rest;
                        done      <= next_last;
                    end else if (wb_q) begin
                        state    <= S_WB;
                        busy     <= 1'b1;
                        wbValid  <= 1'b1;
                        wbOffset <= add_q ? q_n4 : ('0 - q_n4);
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_ldm_sequencer.sv
// tb/tb_arm_ldm_sequencer.sv - self-checking bench for arm_ldm_sequencer
module tb_arm_ldm_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, isLoad, wb, isAdd, pre, stallD, FlushE;
    logic [15:0] regList;
    logic [3:0]  Rn;
    logic        busy, StallF, uopValid, uopLoad, uopPC, wbValid, done;
    logic [3:0]  uopReg;
    logic [7:0]  uopOffset, wbOffset;

    int checks   = 0;
    int failures = 0;

`ifdef LDM_BASE_IN_LIST_EN
    localparam bit BASE_EN = 1'b1;
`else
    localparam bit BASE_EN = 1'b0;
`endif

    arm_ldm_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .regList(regList), .Rn(Rn),
        .isLoad(isLoad), .wb(wb), .isAdd(isAdd), .pre(pre), .stallD(stallD),
        .FlushE(FlushE), .busy(busy), .StallF(StallF), .uopValid(uopValid),
        .uopReg(uopReg), .uopOffset(uopOffset), .uopLoad(uopLoad), .uopPC(uopPC),
        .wbValid(wbValid), .wbOffset(wbOffset), .done(done)
    );

    always #5 clk = ~clk;

    // Launches one instruction and checks every presented micro-op against a list
    // built from the addressing-mode rules; optionally stalls and pokes start while busy.
    task automatic run_seq(input logic [15:0] rl, input logic [3:0] rn, input logic l, w, u, p,
                           input bit rand_ctl, output logic [7:0] last_off, output bit wb_seen);
        int   regs[16];
        int   n, base, nitems, k, guard;
        bit   wbe, stall;
        logic e_valid[18], e_pc[18], e_wbv[18], e_done[18], e_stf[18], e_busy[18];
        logic [3:0] e_reg[18];
        logic [7:0] e_off[18], e_wboff[18];
        n = 0;
        for (int r = 0; r < 16; r++) if (rl[r]) begin regs[n] = r; n++; end
        wbe = w && !(BASE_EN && l && rl[rn]);
        case ({p, u})
            2'b01:   base = 0;
            2'b11:   base = 4;
            2'b00:   base = 4 - 4 * n;
            default: base = -4 * n;
        endcase
        for (int i = 0; i < n; i++) begin
            e_valid[i] = 1'b1; e_reg[i] = 4'(regs[i]); e_off[i] = 8'(base + 4 * i);
            e_pc[i] = l && (regs[i] == 15); e_wbv[i] = 1'b0; e_wboff[i] = 8'h00;
            e_done[i] = (i == n - 1) && !wbe; e_stf[i] = !e_done[i]; e_busy[i] = 1'b1;
        end
        nitems = n;
        if (wbe || n == 0) begin
            e_valid[n] = 1'b0; e_reg[n] = 4'h0; e_off[n] = 8'h00; e_pc[n] = 1'b0;
            e_wbv[n] = wbe; e_wboff[n] = wbe ? (u ? 8'(4 * n) : 8'(-4 * n)) : 8'h00;
            e_done[n] = 1'b1; e_stf[n] = 1'b0; e_busy[n] = wbe;
            nitems = n + 1;
        end
        last_off = 8'h00; wb_seen = 1'b0;
        regList = rl; Rn = rn; isLoad = l; wb = w; isAdd = u; pre = p; stallD = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; guard = 0;
        while (k < nitems && guard < 200) begin
            guard++;
            if (uopValid === 1'b1) last_off = uopOffset;
            if (wbValid === 1'b1) wb_seen = 1'b1;
            checks++;
            if (uopValid !== e_valid[k]) begin failures++; $display("FAIL uopValid rl=%h k=%0d got=%b exp=%b", rl, k, uopValid, e_valid[k]); end
            if (e_valid[k]) begin
                checks += 4;
                if (uopReg !== e_reg[k]) begin failures++; $display("FAIL uopReg rl=%h k=%0d got=%0d exp=%0d", rl, k, uopReg, e_reg[k]); end
                if (uopOffset !== e_off[k]) begin failures++; $display("FAIL uopOffset rl=%h k=%0d got=%h exp=%h", rl, k, uopOffset, e_off[k]); end
                if (uopPC !== e_pc[k]) begin failures++; $display("FAIL uopPC rl=%h k=%0d got=%b exp=%b", rl, k, uopPC, e_pc[k]); end
                if (uopLoad !== l) begin failures++; $display("FAIL uopLoad rl=%h k=%0d got=%b exp=%b", rl, k, uopLoad, l); end
            end
            checks += 4;
            if (wbValid !== e_wbv[k]) begin failures++; $display("FAIL wbValid rl=%h k=%0d got=%b exp=%b", rl, k, wbValid, e_wbv[k]); end
            if (done !== e_done[k]) begin failures++; $display("FAIL done rl=%h k=%0d got=%b exp=%b", rl, k, done, e_done[k]); end
            if (StallF !== e_stf[k]) begin failures++; $display("FAIL StallF rl=%h k=%0d got=%b exp=%b", rl, k, StallF, e_stf[k]); end
            if (busy !== e_busy[k]) begin failures++; $display("FAIL busy rl=%h k=%0d got=%b exp=%b", rl, k, busy, e_busy[k]); end
            if (e_wbv[k]) begin
                checks++;
                if (wbOffset !== e_wboff[k]) begin failures++; $display("FAIL wbOffset rl=%h got=%h exp=%h", rl, wbOffset, e_wboff[k]); end
            end
            stall = rand_ctl && ($urandom_range(0, 3) == 0);
            if (rand_ctl && e_busy[k]) begin
                start = 1'($urandom_range(0, 1)); regList = 16'($urandom);
                Rn = 4'($urandom); isLoad = 1'($urandom); wb = 1'($urandom);
                isAdd = 1'($urandom); pre = 1'($urandom);
            end
            stallD = stall;
            @(negedge clk);
            start = 1'b0; stallD = 1'b0;
            if (!stall) k++;
        end
        checks++;
        if (guard >= 200) begin failures++; $display("FAIL seq_budget rl=%h k=%0d got=%0d exp=%0d", rl, k, guard, nitems); end
        checks++;
        if ({busy, uopValid, wbValid, done, StallF} !== 5'b0) begin
            failures++; $display("FAIL idle_after rl=%h got=%b exp=00000", rl, {busy, uopValid, wbValid, done, StallF});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stallD = 1'b0; FlushE = 1'b0; regList = 16'h0; Rn = 4'h0;
        isLoad = 1'b0; wb = 1'b0; isAdd = 1'b0; pre = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, StallF, uopValid, uopReg, uopOffset, uopLoad, uopPC, wbValid, wbOffset, done} !== 27'h0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {busy, StallF, uopValid, uopReg, uopOffset, uopLoad, uopPC, wbValid, wbOffset, done});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        regList = 16'h00FF; Rn = 4'h2; isLoad = 1'b1; wb = 1'b1; isAdd = 1'b1; pre = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, StallF, uopValid, uopReg, uopOffset, wbValid, done} !== 17'h0) begin
            failures++; $display("FAIL reset_mid got=%h exp=0", {busy, StallF, uopValid, uopReg, uopOffset, wbValid, done});
        end
        @(negedge clk);
        checks++;
        if ({busy, uopValid, wbValid} !== 3'b0) begin failures++; $display("FAIL reset_mid_hold got=%b exp=000", {busy, uopValid, wbValid}); end
    endtask

    task automatic test_directed();
        logic [7:0] lo;
        bit ws;
        run_seq(16'h0016, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, lo, ws);
        run_seq(16'h40F0, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, lo, ws);
        run_seq(16'h8000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, lo, ws);
        checks++;
        if (ws !== 1'b0) begin failures++; $display("FAIL ldm_pc_no_wb got=%b exp=0", ws); end
        run_seq(16'hFFFF, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, lo, ws);
        checks++;
        if (lo !== 8'h40) begin failures++; $display("FAIL full_ldmib_last got=%h exp=40", lo); end
        run_seq(16'hFFFF, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, lo, ws);
        run_seq(16'h0000, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, lo, ws);
        run_seq(16'h0000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lo, ws);
    endtask

    task automatic test_base_in_list();
        logic [7:0] lo;
        bit ws;
        run_seq(16'h0006, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, lo, ws);
        checks++;
        if (ws !== !BASE_EN) begin failures++; $display("FAIL base_in_list_wb got=%b exp=%b", ws, !BASE_EN); end
        run_seq(16'h0006, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, lo, ws);
        checks++;
        if (ws !== 1'b1) begin failures++; $display("FAIL base_in_list_store got=%b exp=1", ws); end
    endtask

    task automatic test_stall_flush();
        regList = 16'h000F; Rn = 4'h8; isLoad = 1'b1; wb = 1'b1; isAdd = 1'b1; pre = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({uopValid, uopReg, uopOffset} !== {1'b1, 4'd1, 8'h04}) begin
            failures++; $display("FAIL stall_second_uop got=%h exp=%h", {uopValid, uopReg, uopOffset}, {1'b1, 4'd1, 8'h04});
        end
        stallD = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({uopValid, uopReg, uopOffset, StallF, busy, done} !== {1'b1, 4'd1, 8'h04, 1'b1, 1'b1, 1'b0}) begin
                failures++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, {uopValid, uopReg, uopOffset, StallF, busy, done}, {1'b1, 4'd1, 8'h04, 1'b1, 1'b1, 1'b0});
            end
        end
        stallD = 1'b0;
        @(negedge clk);
        checks++;
        if ({uopValid, uopReg, uopOffset} !== {1'b1, 4'd2, 8'h08}) begin
            failures++; $display("FAIL stall_resume got=%h exp=%h", {uopValid, uopReg, uopOffset}, {1'b1, 4'd2, 8'h08});
        end
        FlushE = 1'b1; stallD = 1'b1; start = 1'b1;
        @(negedge clk);
        FlushE = 1'b0; stallD = 1'b0; start = 1'b0;
        checks++;
        if ({busy, StallF, uopValid, uopReg, uopOffset, uopLoad, uopPC, wbValid, wbOffset, done} !== 27'h0) begin
            failures++; $display("FAIL flush_outputs got=%h exp=0", {busy, StallF, uopValid, uopReg, uopOffset, uopLoad, uopPC, wbValid, wbOffset, done});
        end
        @(negedge clk);
        checks++;
        if ({busy, uopValid, wbValid, done} !== 4'b0) begin failures++; $display("FAIL flush_stays_idle got=%b exp=0000", {busy, uopValid, wbValid, done}); end
        FlushE = 1'b1; start = 1'b1;
        @(negedge clk);
        FlushE = 1'b0; start = 1'b0;
        checks++;
        if ({busy, uopValid, done} !== 3'b0) begin failures++; $display("FAIL flush_blocks_start got=%b exp=000", {busy, uopValid, done}); end
    endtask

    task automatic test_random();
        logic [7:0] lo;
        bit ws;
        logic [15:0] rl;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0:       rl = 16'h0000;
                1:       rl = 16'hFFFF;
                2:       rl = 16'($urandom) & 16'($urandom);
                default: rl = 16'($urandom);
            endcase
            run_seq(rl, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, lo, ws);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_base_in_list();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arm_ldm_sequencer.md
Name: arm_ldm_sequencer

Overview:
- Micro-op sequencer for ARM LDM/STM in the combi core's D stage.
- Accepts a decoded block-transfer instruction and emits one register transfer per cycle: register index and signed byte offset from the base.
- Emits an optional base-writeback micro-op at the end.
- Holds fetch (StallF) until the sequence drains; replaces the fixed two-step uCnt scheme so any 16-bit register list is supported.

Parameters:
NREGS, 16, register-list width / architectural register count
OFFW, 8, width of signed byte-offset outputs (must hold ±4*NREGS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  valid LDM/STM decoded in D (armD & wasNotFlushed); sampled only in IDLE
regList  in  NREGS  instr[15:0]
Rn  in  4  base register, instr[19:16]
isLoad  in  1  instr[20]
wb  in  1  W bit, instr[21]
isAdd  in  1  U bit, instr[23]
pre  in  1  P bit, instr[24]
stallD  in  1  hazard stall; freezes sequencer
FlushE  in  1  pipeline flush; aborts sequence
busy  out  1  sequence in progress
StallF  out  1  hold fetch/PC
uopValid  out  1  transfer micro-op valid this cycle
uopReg  out  4  register transferred
uopOffset  out  OFFW  signed byte offset from base for this transfer
uopLoad  out  1  latched isLoad
uopPC  out  1  load targeting R15 (drives PCSrc)
wbValid  out  1  writeback micro-op valid (Rn <- Rn + wbOffset)
wbOffset  out  OFFW  signed ±4*N
done  out  1  one-cycle pulse on final micro-op

Behaviour:
- States: IDLE, XFER, WB. All outputs are registered.
- Reset: state=IDLE; all outputs 0; internal list/count/index cleared. Applies mid-sequence; no further micro-ops are issued.
- IDLE:
  - start=1 & ~FlushE & ~stallD: latch regList, Rn, isLoad, wb, isAdd, pre.
  - N = popcount(regList) (0..16).
  - startOff (signed OFFW): IA(P0U1)=0; IB(P1U1)=+4; DA(P0U0)=-4N+4; DB(P1U0)=-4N.
  - Next state: XFER if N>0; else WB if wb; else stay IDLE and pulse done next cycle.
  - start is ignored while busy.
- XFER: each cycle with ~stallD:
  - uopValid=1; uopReg = index of lowest set bit of remaining list; clear that bit.
  - uopOffset = startOff + 4*i, where i = transfers already issued (ascending addresses for ascending registers in all modes).
  - uopPC = uopLoad & (uopReg==15).
  - After issuing the last set bit: go to WB if wb, else IDLE with done=1 on that same micro-op.
- WB: one cycle; wbValid=1; wbOffset = isAdd ? +4N : -4N; done=1; next state IDLE.
- Latency: first micro-op appears the cycle after start is accepted. Total busy cycles = N + wb (min 1 if N=0 & wb).
- stallD=1: state, list and all outputs hold their previous values; uopValid is not re-counted as a new transfer.
- FlushE=1: next cycle state=IDLE; uopValid=wbValid=done=busy=StallF=0. FlushE has priority over stallD and start.
- busy = (state != IDLE).
- StallF = 1 from the cycle after accept until the cycle before the final micro-op; it drops on the cycle the last micro-op (transfer or WB) is presented.
- Arithmetic: offsets computed in OFFW-bit two's complement; N=16 DB gives -64, IB gives +64 max.

Optional Feature:
LDM_BASE_IN_LIST_EN
- Defined: for a load whose regList contains Rn, the writeback micro-op is suppressed (the loaded value wins). The sequence ends after the last transfer with done. Stores are unaffected.
- Undefined: writeback is always issued when wb=1, per the rules above.

Test Plan:
- LDMIA R0!, {R1,R2,R4}: start, regList=0x0016, P0 U1 W1 L1 -> uops (R1,0),(R2,+4),(R4,+8); then wbValid with wbOffset=+12; done on the WB cycle; StallF high for 3 cycles.
- STMDB R13!, {R4-R7,R14}: regList=0x40F0, P1 U0 W1 L0 -> offsets -20,-16,-12,-8,-4 for R4,R5,R6,R7,R14; then wbOffset=-20.
- LDMIA R0, {R15}: regList=0x8000, W0 -> single uop R15 offset 0, uopPC=1, done same cycle, no wbValid.
- Full list LDMIB, regList=0xFFFF -> 16 uops, offsets +4..+64, uopOffset=8'h40 on the last; then IDLE.
- stallD pulsed 2 cycles during the 2nd uop of a 4-register list, then FlushE mid-sequence -> outputs frozen during stall; idle with all outputs 0 the cycle after flush.
- With LDM_BASE_IN_LIST_EN: LDMIA R1!, {R1,R2} -> 2 uops, no wbValid; without the macro -> wbOffset=+8 issued.
